// File: rtl/key_debouncer_pkg.sv
// Shared constants and types for the push-button debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package key_debouncer_pkg;

   // System clock and the desired debounce sample rate
   localparam int SYS_CLK_HZ        = 50_000_000;
   localparam int SAMPLE_HZ         = 1_000;

   // Defaults: 1 ms sample tick, 20 ms of stable level before accepting a change
   localparam int DEF_PRESCALE      = SYS_CLK_HZ / SAMPLE_HZ;
   localparam int DEF_STABLE_TICKS  = 20;

   // Raw pin level that means "button pushed" (buttons pull the pin low)
   localparam logic KEY_PRESSED_RAW = 1'b0;

   // Accepted key state; encoding doubles as the active-high clean level
   typedef enum logic {
      KEY_RELEASED = 1'b0,
      KEY_PRESSED  = 1'b1
   } key_state_t;

   // Width of a counter that must hold values 0..n-1 with one bit of headroom
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/key_debouncer_channel.sv
// One debounce channel: 2-flop synchronizer, stability counter, accepted state, edge pulses.
// Latency: 2 cycles sync, then STABLE_TICKS ticks of steady mismatch; pulses registered with the level.
// Backpressure: none; free-running, outputs valid every cycle.
module key_debounce_channel
   import key_debouncer_pkg::*;
#(
   parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw_n,
   input  logic tick,
   output logic key_clean,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int             CW       = cnt_width(STABLE_TICKS);
   localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic          sync;
   key_state_t    state;
   key_state_t    state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          press_nxt;
   logic          release_nxt;

   // Two-flop synchronizer on the asynchronous pin; resets to the released level
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q1 <= ~KEY_PRESSED_RAW;
         sync_q2 <= ~KEY_PRESSED_RAW;
      end else begin
         sync_q1 <= key_raw_n;
         sync_q2 <= sync_q1;
      end
   end

   // Active-high synchronised level
   assign sync = (sync_q2 == KEY_PRESSED_RAW);

   // State, stability counter and edge pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= KEY_RELEASED;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
      end
   end

   // Qualification: any agreement restarts the count; a change is taken on the last mismatched tick
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      if (sync == logic'(state)) begin
         cnt_nxt = '0;
      end else if (tick) begin
         if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            if (state == KEY_RELEASED) begin
               state_nxt = KEY_PRESSED;
               press_nxt = 1'b1;
            end else begin
               state_nxt   = KEY_RELEASED;
               release_nxt = 1'b1;
            end
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
      end
   end

   assign key_clean = (state == KEY_PRESSED);

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS active-low push buttons into clean active-high levels plus press/release pulses.
// Latency: worst case 2 + PRESCALE*STABLE_TICKS cycles from pin change to keys_clean.
// Backpressure: none; free-running, outputs valid every cycle.
module key_debouncer
   import key_debouncer_pkg::*;
#(
   parameter int N_KEYS       = 4,
   parameter int PRESCALE     = DEF_PRESCALE,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] keys_raw_n,
   output logic [N_KEYS-1:0] keys_clean,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse
);

   // A PRESCALE of 1 still needs a 1-bit counter that simply sits at zero
   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_cnt;
   logic          tick;

   assign tick = (pre_cnt == PRE_LAST);

   // Shared sample-tick prescaler, counts 0..PRESCALE-1 and wraps
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   // One independent channel per key, all stepping on the same tick
   for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
      key_debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_chan (
         .clk           (clk),
         .reset         (reset),
         .key_raw_n     (keys_raw_n[i]),
         .tick          (tick),
         .key_clean     (keys_clean[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench: directed sequences on a PRESCALE=4/STABLE_TICKS=3 instance,
// plus a per-cycle vector table on a PRESCALE=1/STABLE_TICKS=1 instance.
// Inputs are driven 1 ns after the rising edge; outputs sampled at the same point.
module tb_key_debouncer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] keys_raw_n;
   logic [3:0] keys_clean;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
   logic [3:0] keys_raw_n2;
   logic [3:0] keys_clean2;
   logic [3:0] press_pulse2;
   logic [3:0] release_pulse2;

   always #5 clk = ~clk;

   key_debouncer #(.N_KEYS(4), .PRESCALE(4), .STABLE_TICKS(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .keys_raw_n    (keys_raw_n),
      .keys_clean    (keys_clean),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   key_debouncer #(.N_KEYS(4), .PRESCALE(1), .STABLE_TICKS(1)) dut_fast (
      .clk           (clk),
      .reset         (reset),
      .keys_raw_n    (keys_raw_n2),
      .keys_clean    (keys_clean2),
      .press_pulse   (press_pulse2),
      .release_pulse (release_pulse2)
   );

   typedef struct {
      logic [3:0] raw_n;
      logic [3:0] clean;
      logic [3:0] press;
      logic [3:0] rel;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int since_rst = 0;
   int press_cnt [4];
   int rel_cnt   [4];
   int press_at  [4];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) begin
         press_cnt[i] = 0;
         rel_cnt[i]   = 0;
         press_at[i]  = -1;
      end
   endtask

   // One clock: sample main-DUT pulses just after the edge
   task automatic step();
      @(posedge clk);
      if (reset) since_rst = 0;
      else since_rst++;
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (press_pulse[i]) begin
            press_cnt[i]++;
            press_at[i] = cyc;
         end
         if (release_pulse[i]) rel_cnt[i]++;
      end
   endtask

   // Bounded wait for (keys_clean & mask) == val; lat = clocks taken
   task automatic wait_clean(input logic [3:0] mask, input logic [3:0] val,
                             input int limit, output int lat);
      lat = 0;
      while (((keys_clean & mask) != val) && (lat < limit)) begin
         step();
         lat++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      vec_t vt [13];

      // Fast instance: 1-cycle pulses through a 2-cycle synchronizer, tick every cycle
      vt[0]  = '{4'hF, 4'h0, 4'h0, 4'h0};
      vt[1]  = '{4'hE, 4'h0, 4'h0, 4'h0};
      vt[2]  = '{4'hF, 4'h0, 4'h0, 4'h0};
      vt[3]  = '{4'hF, 4'h1, 4'h1, 4'h0};
      vt[4]  = '{4'hF, 4'h0, 4'h0, 4'h1};
      vt[5]  = '{4'hF, 4'h0, 4'h0, 4'h0};
      vt[6]  = '{4'h5, 4'h0, 4'h0, 4'h0};
      vt[7]  = '{4'h5, 4'h0, 4'h0, 4'h0};
      vt[8]  = '{4'h5, 4'hA, 4'hA, 4'h0};
      vt[9]  = '{4'hF, 4'hA, 4'h0, 4'h0};
      vt[10] = '{4'hF, 4'hA, 4'h0, 4'h0};
      vt[11] = '{4'hF, 4'h0, 4'h0, 4'hA};
      vt[12] = '{4'hF, 4'h0, 4'h0, 4'h0};

      // 1. Reset with all keys held down
      reset       = 1'b1;
      keys_raw_n  = 4'h0;
      keys_raw_n2 = 4'hF;
      clear_counts();
      repeat (4) step();
      check("rst_clean", int'(keys_clean), 0);
      check("rst_press", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
      check("rst_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 0);
      check("rst_fast_clean", int'(keys_clean2), 0);

      reset = 1'b0;
      clear_counts();
      wait_clean(4'hF, 4'hF, 30, lat);
      check("t1_clean", int'(keys_clean), 15);
      check("t1_latency", lat, 12);
      repeat (3) step();
      for (int i = 0; i < 4; i++) check($sformatf("t1_press_cnt%0d", i), press_cnt[i], 1);
      check("t1_same_cycle_3", press_at[3], press_at[0]);

      // Release everything
      keys_raw_n = 4'hF;
      clear_counts();
      wait_clean(4'hF, 4'h0, 30, lat);
      check_range("t1_rel_latency", lat, 11, 14);
      repeat (3) step();
      check("t1_rel_clean", int'(keys_clean), 0);
      for (int i = 0; i < 4; i++) check($sformatf("t1_rel_cnt%0d", i), rel_cnt[i], 1);

      // 2. Clean press and release of key 0
      keys_raw_n = 4'hE;
      clear_counts();
      wait_clean(4'h1, 4'h1, 30, lat);
      check_range("t2_press_latency", lat, 11, 14);
      repeat (3) step();
      check("t2_clean", int'(keys_clean), 1);
      check("t2_press_cnt0", press_cnt[0], 1);
      check("t2_press_other", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
      keys_raw_n = 4'hF;
      clear_counts();
      wait_clean(4'h1, 4'h0, 30, lat);
      check_range("t2_rel_latency", lat, 11, 14);
      repeat (3) step();
      check("t2_rel_clean", int'(keys_clean), 0);
      check("t2_rel_cnt0", rel_cnt[0], 1);
      check("t2_press_after_rel", press_cnt[0], 0);

      // 3. Bounce on key 1: low 6, high 3, low 5, then high
      clear_counts();
      keys_raw_n = 4'hD; repeat (6) step();
      keys_raw_n = 4'hF; repeat (3) step();
      keys_raw_n = 4'hD; repeat (5) step();
      keys_raw_n = 4'hF; repeat (20) step();
      check("t3_bounce_clean", int'(keys_clean), 0);
      check("t3_bounce_press", press_cnt[1], 0);
      check("t3_bounce_release", rel_cnt[1], 0);
      keys_raw_n = 4'hD;
      wait_clean(4'h2, 4'h2, 30, lat);
      check_range("t3_hold_latency", lat, 11, 14);
      repeat (2) step();
      check("t3_press_cnt1", press_cnt[1], 1);
      keys_raw_n = 4'hF;
      repeat (20) step();
      check("t3_rel_clean", int'(keys_clean), 0);

      // 4. Keys 2 and 3 together while key 0 bounces every 3 cycles
      clear_counts();
      for (int c = 0; c < 24; c++) begin
         keys_raw_n = {2'b00, 1'b1, (((c / 3) % 2) == 1)};
         step();
      end
      keys_raw_n = 4'hF;
      check("t4_clean", int'(keys_clean), 12);
      check("t4_press_cnt2", press_cnt[2], 1);
      check("t4_press_cnt3", press_cnt[3], 1);
      check("t4_same_cycle", press_at[3], press_at[2]);
      check("t4_key0_press", press_cnt[0], 0);
      repeat (20) step();
      check("t4_rel_clean", int'(keys_clean), 0);

      // 5. Reset while key 1 has counted two ticks
      for (int k = 0; k < 4 && (since_rst % 4) != 0; k++) step();
      keys_raw_n = 4'hD;
      clear_counts();
      repeat (9) step();
      check("t5_pre_clean", int'(keys_clean), 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_rst_clean", int'(keys_clean), 0);
      check("t5_no_pulse", press_cnt[1], 0);
      clear_counts();
      wait_clean(4'h2, 4'h2, 30, lat);
      check("t5_requal_latency", lat, 12);
      repeat (2) step();
      check("t5_press_cnt1", press_cnt[1], 1);
      keys_raw_n = 4'hF;
      repeat (20) step();

      // 6. Fast instance vector table
      for (int i = 0; i < 13; i++) begin
         keys_raw_n2 = vt[i].raw_n;
         step();
         check($sformatf("t6_clean[%0d]", i), int'(keys_clean2), int'(vt[i].clean));
         check($sformatf("t6_press[%0d]", i), int'(press_pulse2), int'(vt[i].press));
         check($sformatf("t6_release[%0d]", i), int'(release_pulse2), int'(vt[i].rel));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
